// File: rtl/rsa_pkg.sv
// Shared constants and FSM state codes for the RSA key-generation sequencer.
package rsa_pkg;

  localparam int unsigned RSA_WIDTH = 64;
  localparam int unsigned E_STEP    = 2;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StCalc    = 4'd1;
  localparam logic [3:0] StLaunch  = 4'd2;
  localparam logic [3:0] StWait    = 4'd3;
  localparam logic [3:0] StRelease = 4'd4;
  localparam logic [3:0] StEval    = 4'd5;
  localparam logic [3:0] StFix     = 4'd6;
  localparam logic [3:0] StVerify  = 4'd7;
  localparam logic [3:0] StDone    = 4'd8;
  localparam logic [3:0] StFail    = 4'd9;

  localparam logic [1:0] HsIdle    = 2'd0;
  localparam logic [1:0] HsWait    = 2'd1;
  localparam logic [1:0] HsRelease = 2'd2;

endpackage

// File: rtl/rsa_eu_handshake.sv
// Start/done handshake with the extended-Euclidean engine, plus the per-run watchdog.
module rsa_eu_handshake
  import rsa_pkg::*;
#(
  parameter int unsigned WD_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic eu_done,
  output logic eu_start,
  output logic result_valid,
  output logic timeout
);

  localparam int unsigned WdW = $clog2(WD_CYCLES + 1);

  logic [1:0]     hs_q, hs_d;
  logic [WdW-1:0] wd_q, wd_d;

  always_comb begin
    hs_d         = hs_q;
    wd_d         = wd_q;
    result_valid = 1'b0;
    timeout      = 1'b0;
    case (hs_q)
      HsIdle: begin
        if (go) begin
          hs_d = HsWait;
          wd_d = '0;
        end
      end
      HsWait: begin
        if (eu_done) begin
          hs_d = HsRelease;
        end else if (wd_q == WdW'(WD_CYCLES - 1)) begin
          timeout = 1'b1;
          hs_d    = HsIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      HsRelease: begin
        // The engine only clears done once start has been removed.
        if (!eu_done) begin
          result_valid = 1'b1;
          hs_d         = HsIdle;
        end
      end
      default: hs_d = HsIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q <= HsIdle;
      wd_q <= '0;
    end else begin
      hs_q <= hs_d;
      wd_q <= wd_d;
    end
  end

  assign eu_start = (hs_q == HsWait);

endmodule

// File: rtl/rsa_keygen_ctrl.sv
// RSA key-generation sequencer: n, phi, then e/d search via the Euclidean engine.
// Optional (e*d) mod phi self-check enabled by defining RSA_KEYGEN_VERIFY_EN.
module rsa_keygen_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH     = RSA_WIDTH,
  parameter int unsigned MAX_TRIES = 16,
  parameter int unsigned WD_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH/2-1:0] p,
  input  logic [WIDTH/2-1:0] q,
  input  logic [WIDTH-1:0]   e_init,
  output logic               eu_start,
  output logic [WIDTH-1:0]   eu_a,
  output logic [WIDTH-1:0]   eu_b,
  input  logic [WIDTH-1:0]   eu_gcd,
  input  logic [WIDTH-1:0]   eu_d,
  input  logic               eu_done,
  output logic [WIDTH-1:0]   n,
  output logic [WIDTH-1:0]   e,
  output logic [WIDTH-1:0]   d,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int unsigned HalfW = WIDTH / 2;
  localparam int unsigned TryW  = $clog2(MAX_TRIES + 1);

  logic [3:0]       state_q, state_d;
  logic [HalfW-1:0] p_q, p_d, q_q, q_d;
  logic [WIDTH-1:0] n_q, n_d, phi_q, phi_d, e_q, e_d;
  logic [WIDTH-1:0] gcd_q, gcd_d, dl_q, dl_d, d_q, d_d;
  logic [TryW-1:0]  tries_q, tries_d, tries_inc;
  logic [WIDTH:0]   e_next;
  logic             go, result_valid, timeout;

  assign tries_inc = tries_q + 1'b1;
  // One extra bit so a candidate near the top of the range cannot wrap.
  assign e_next    = {1'b0, e_q} + (WIDTH + 1)'(E_STEP);

`ifdef RSA_KEYGEN_VERIFY_EN
  logic [2*WIDTH-1:0] vrf_prod, vrf_rem;
  logic               vrf_ok;
  assign vrf_prod = {{WIDTH{1'b0}}, e_q} * {{WIDTH{1'b0}}, d_q};
  assign vrf_rem  = vrf_prod % {{WIDTH{1'b0}}, phi_q};
  assign vrf_ok   = (vrf_rem == (2 * WIDTH)'(1));
`endif

  rsa_eu_handshake #(
    .WD_CYCLES(WD_CYCLES)
  ) u_handshake (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .eu_done     (eu_done),
    .eu_start    (eu_start),
    .result_valid(result_valid),
    .timeout     (timeout)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    n_d     = n_q;
    phi_d   = phi_q;
    e_d     = e_q;
    gcd_d   = gcd_q;
    dl_d    = dl_q;
    d_d     = d_q;
    tries_d = tries_q;
    go      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          p_d     = p;
          q_d     = q;
          e_d     = e_init | WIDTH'(1);
          tries_d = '0;
          d_d     = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        n_d     = WIDTH'(p_q) * WIDTH'(q_q);
        phi_d   = WIDTH'(p_q - HalfW'(1)) * WIDTH'(q_q - HalfW'(1));
        state_d = StLaunch;
      end
      StLaunch: begin
        if (phi_q == '0) begin
          state_d = StFail;
        end else begin
          go      = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (eu_done) begin
          gcd_d   = eu_gcd;
          dl_d    = eu_d;
          state_d = StRelease;
        end else if (timeout) begin
          state_d = StFail;
        end
      end
      StRelease: begin
        if (result_valid) state_d = StEval;
      end
      StEval: begin
        if (gcd_q == WIDTH'(1)) begin
          state_d = StFix;
        end else begin
          tries_d = tries_inc;
          if (32'(tries_inc) >= MAX_TRIES || e_next >= {1'b0, phi_q}) begin
            state_d = StFail;
          end else begin
            e_d     = e_next[WIDTH-1:0];
            state_d = StLaunch;
          end
        end
      end
      StFix: begin
        // Engine coefficient is signed; fold it into 0..phi-1.
        d_d = dl_q[WIDTH-1] ? dl_q + phi_q : dl_q;
`ifdef RSA_KEYGEN_VERIFY_EN
        state_d = StVerify;
`else
        state_d = StDone;
`endif
      end
`ifdef RSA_KEYGEN_VERIFY_EN
      StVerify: begin
        state_d = vrf_ok ? StDone : StFail;
      end
`endif
      StDone: begin
        if (!start) state_d = StIdle;
      end
      StFail: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StFail) d_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      p_q     <= '0;
      q_q     <= '0;
      n_q     <= '0;
      phi_q   <= '0;
      e_q     <= '0;
      gcd_q   <= '0;
      dl_q    <= '0;
      d_q     <= '0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      n_q     <= n_d;
      phi_q   <= phi_d;
      e_q     <= e_d;
      gcd_q   <= gcd_d;
      dl_q    <= dl_d;
      d_q     <= d_d;
      tries_q <= tries_d;
    end
  end

  assign eu_a  = phi_q;
  assign eu_b  = e_q;
  assign n     = n_q;
  assign e     = e_q;
  assign d     = d_q;
  assign done  = (state_q == StDone);
  assign error = (state_q == StFail);
  assign busy  = (state_q != StIdle) && (state_q != StDone) && (state_q != StFail);

endmodule
